// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master command port.
// Sequences a single command from accept to response.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int START_TIMEOUT  = 1024
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_read_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_device_address,
  input  logic [NUM_REQ*REGISTER_WIDTH-1:0] req_register_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_mosi_data,
  input  logic [15:0]                       divider_cfg,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic                              rsp_error,
  output logic [DATA_WIDTH-1:0]             rsp_miso_data,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              enable,
  output logic                              read_write,
  output logic [DATA_WIDTH-1:0]             mosi_data,
  output logic [REGISTER_WIDTH-1:0]         register_address,
  output logic [ADDRESS_WIDTH-1:0]          device_address,
  output logic [15:0]                       divider,
  input  logic [DATA_WIDTH-1:0]             miso_data,
  input  logic                              busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } state_t;

  state_t state;
  state_t state_next;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic          any_valid;
  logic          accept;
  logic [CW-1:0] count;
  logic          timed_out;

  logic [ADDRESS_WIDTH-1:0]  dev_arr [NUM_REQ];
  logic [REGISTER_WIDTH-1:0] reg_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]     dat_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dev_arr[g] =
      req_device_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign reg_arr[g] =
      req_register_address[g*REGISTER_WIDTH +: REGISTER_WIDTH];
    assign dat_arr[g] =
      req_mosi_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search upward from the last owner so it ends up lowest priority.
  always_comb begin
    winner    = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  assign accept    = (state == IDLE) && !busy && any_valid;
  assign timed_out = !busy && (count == TO_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (accept) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy)           state_next = WAIT_DONE;
        else if (timed_out) state_next = RESPOND;
      end
      WAIT_DONE: if (!busy) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing is offered while held in reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    enable    = 1'b0;
    unique case (1'b1)
      (state == IDLE):    req_ready[winner] = accept && reset_n;
      (state == ISSUE):   enable = 1'b1;
      (state == RESPOND): rsp_valid[grant_id] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant       <= IW'(NUM_REQ - 1);
      grant_id         <= '0;
      read_write       <= 1'b0;
      mosi_data        <= '0;
      register_address <= '0;
      device_address   <= '0;
      divider          <= '0;
      count            <= '0;
      rsp_error        <= 1'b0;
      rsp_miso_data    <= '0;
    end else begin
      if (accept) begin
        grant_id         <= winner;
        read_write       <= req_read_write[winner];
        device_address   <= dev_arr[winner];
        register_address <= reg_arr[winner];
        mosi_data        <= dat_arr[winner];
        divider          <= divider_cfg;
      end
      if (state == ISSUE) begin
        count <= '0;
      end
      if (state == WAIT_BUSY && !busy) begin
        if (timed_out) begin
          rsp_error     <= 1'b1;
          rsp_miso_data <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (state == WAIT_DONE && !busy) begin
        rsp_error     <= 1'b0;
        rsp_miso_data <= read_write ? miso_data : '0;
      end
      if (state == RESPOND) begin
        last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter.
// A small behavioural master model answers enable pulses with busy.
module tb_i2c_master_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int RW = 8;
  localparam int AW = 7;
  localparam int TO = 16;

  logic          clock;
  logic          reset_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_read_write;
  logic [NR*AW-1:0] req_device_address;
  logic [NR*RW-1:0] req_register_address;
  logic [NR*DW-1:0] req_mosi_data;
  logic [15:0]   divider_cfg;
  logic [NR-1:0] rsp_valid;
  logic          rsp_error;
  logic [DW-1:0] rsp_miso_data;
  logic [1:0]    grant_id;
  logic          enable;
  logic          read_write;
  logic [DW-1:0] mosi_data;
  logic [RW-1:0] register_address;
  logic [AW-1:0] device_address;
  logic [15:0]   divider;
  logic [DW-1:0] miso_data;
  logic          busy;

  logic          force_busy;
  logic          model_busy;
  int            model_on;
  int            model_delay;
  int            model_len;
  logic [7:0]    model_miso;
  int            pend;
  int            run;

  int cyc;
  int checks;
  int errors;

  assign busy      = force_busy | model_busy;
  assign miso_data = model_miso;

  i2c_master_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .REGISTER_WIDTH(RW),
    .ADDRESS_WIDTH(AW),
    .START_TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_read_write(req_read_write),
    .req_device_address(req_device_address),
    .req_register_address(req_register_address),
    .req_mosi_data(req_mosi_data),
    .divider_cfg(divider_cfg),
    .rsp_valid(rsp_valid),
    .rsp_error(rsp_error),
    .rsp_miso_data(rsp_miso_data),
    .grant_id(grant_id),
    .enable(enable),
    .read_write(read_write),
    .mosi_data(mosi_data),
    .register_address(register_address),
    .device_address(device_address),
    .divider(divider),
    .miso_data(miso_data),
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Master model: busy rises model_delay cycles after enable,
  // stays high model_len cycles.
  initial begin
    model_busy = 1'b0;
    pend = 0;
    run  = 0;
    forever begin
      @(posedge clock);
      #2;
      if (!reset_n) begin
        pend = 0;
        run  = 0;
      end else if (enable && model_on != 0) begin
        pend = model_delay;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) run = model_len;
      end
      model_busy = (run > 0);
      if (run > 0) run--;
    end
  end

  task automatic set_req(input int i, input logic rw,
                         input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] dat);
    req_read_write[i] = rw;
    req_device_address[i*AW +: AW] = dev;
    req_register_address[i*RW +: RW] = rg;
    req_mosi_data[i*DW +: DW] = dat;
  endtask

  task automatic run_cmd(
    input  int i, input logic rw, input logic [6:0] dev,
    input  logic [7:0] rg, input logic [7:0] dat, input logic [15:0] div,
    output int t_acc, output int t_en, output int n_en,
    output int t_rsp, output int t_bl, output logic [3:0] rv,
    output logic er, output logic [7:0] md, output logic [1:0] gid,
    output int hold_bad);
    t_acc = -1; t_en = -1; n_en = 0; t_rsp = -1; t_bl = -1;
    rv = '0; er = 1'b0; md = '0; gid = '0; hold_bad = 0;
    @(negedge clock);
    set_req(i, rw, dev, rg, dat);
    divider_cfg  = div;
    req_valid[i] = 1'b1;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (req_ready[i]) begin
        t_acc = cyc;
        break;
      end
      @(negedge clock); #1;
    end
    @(negedge clock);
    req_valid[i] = 1'b0;
    divider_cfg  = ~div;
    #1;
    if (t_acc < 0) return;
    for (int k = 0; k < 100; k++) begin
      if (enable) begin
        n_en++;
        t_en = cyc;
      end
      if (busy) begin
        t_bl = cyc;
        if ({read_write, device_address, register_address, mosi_data, divider}
            !== {rw, dev, rg, dat, div}) hold_bad++;
      end
      if (rsp_valid != 0) begin
        t_rsp = cyc; rv = rsp_valid; er = rsp_error;
        md = rsp_miso_data; gid = grant_id;
        break;
      end
      @(negedge clock); #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req_valid = '1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 4'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid);
    end
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL reset_enable got %b want 0", enable);
    end
    checks++;
    if ({grant_id, rsp_error, rsp_miso_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_rsp_side got %h want 0",
               {grant_id, rsp_error, rsp_miso_data});
    end
    checks++;
    if ({read_write, device_address, register_address, mosi_data, divider}
        !== 40'h0) begin
      errors++;
      $display("FAIL reset_master_side got %h want 0",
               {read_write, device_address, register_address, mosi_data, divider});
    end
    @(negedge clock);
    req_valid = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_write;
    int ta, te, ne, tr, tb; logic [3:0] rv; logic er;
    logic [7:0] md; logic [1:0] gid; int hb;
    model_on = 1; model_delay = 1; model_len = 20; model_miso = 8'h33;
    run_cmd(0, 1'b0, 7'h50, 8'h10, 8'hA5, 16'd250,
            ta, te, ne, tr, tb, rv, er, md, gid, hb);
    checks++;
    if (te - ta !== 1) begin
      errors++; $display("FAIL wr_enable_time got %0d want 1", te - ta);
    end
    checks++;
    if (ne !== 1) begin
      errors++; $display("FAIL wr_enable_pulses got %0d want 1", ne);
    end
    checks++;
    if (hb !== 0 || tb < 0) begin
      errors++; $display("FAIL wr_hold got %0d bad cycles (last busy %0d) want 0", hb, tb);
    end
    checks++;
    if (tr - ta !== 23) begin
      errors++; $display("FAIL wr_latency got %0d want 23", tr - ta);
    end
    checks++;
    if (tr - tb !== 2) begin
      errors++; $display("FAIL wr_after_busy got %0d want 2", tr - tb);
    end
    checks++;
    if (rv !== 4'b0001) begin
      errors++; $display("FAIL wr_rsp_valid got %b want 0001", rv);
    end
    checks++;
    if ({er, md} !== 9'h0) begin
      errors++; $display("FAIL wr_rsp_data got err %b data %h want 0 00", er, md);
    end
    checks++;
    if (gid !== 2'd0) begin
      errors++; $display("FAIL wr_grant got %0d want 0", gid);
    end
  endtask

  task automatic test_read;
    int ta, te, ne, tr, tb; logic [3:0] rv; logic er;
    logic [7:0] md; logic [1:0] gid; int hb;
    model_on = 1; model_delay = 1; model_len = 1; model_miso = 8'h71;
    run_cmd(2, 1'b1, 7'h68, 8'h75, 8'h00, 16'd100,
            ta, te, ne, tr, tb, rv, er, md, gid, hb);
    checks++;
    if (rv !== 4'b0100) begin
      errors++; $display("FAIL rd_rsp_valid got %b want 0100", rv);
    end
    checks++;
    if (md !== 8'h71 || er !== 1'b0) begin
      errors++; $display("FAIL rd_data got err %b data %h want 0 71", er, md);
    end
    checks++;
    if (gid !== 2'd2) begin
      errors++; $display("FAIL rd_grant got %0d want 2", gid);
    end
    checks++;
    if (tr - ta !== 4) begin
      errors++; $display("FAIL rd_min_latency got %0d want 4", tr - ta);
    end
    checks++;
    if (hb !== 0) begin
      errors++; $display("FAIL rd_hold got %0d want 0", hb);
    end
  endtask

  task automatic test_timeout;
    int ta, te, ne, tr, tb; logic [3:0] rv; logic er;
    logic [7:0] md; logic [1:0] gid; int hb;
    model_on = 0; model_miso = 8'h5C;
    run_cmd(3, 1'b1, 7'h22, 8'h01, 8'h00, 16'd7,
            ta, te, ne, tr, tb, rv, er, md, gid, hb);
    checks++;
    if (tr - te !== 17) begin
      errors++; $display("FAIL to_latency got %0d want 17", tr - te);
    end
    checks++;
    if (rv !== 4'b1000) begin
      errors++; $display("FAIL to_rsp_valid got %b want 1000", rv);
    end
    checks++;
    if (er !== 1'b1 || md !== 8'h00) begin
      errors++; $display("FAIL to_error got err %b data %h want 1 00", er, md);
    end
    @(negedge clock); #1;
    checks++;
    if (rsp_error !== 1'b1 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL to_hold got err %b valid %b want 1 0000", rsp_error, rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] order [5];
    logic [1:0] want  [5];
    int n, multi;
    want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2;
    want[3] = 2'd3; want[4] = 2'd0;
    for (int k = 0; k < 5; k++) order[k] = 2'bxx;
    n = 0; multi = 0;
    model_on = 1; model_delay = 1; model_len = 2; model_miso = 8'h00;
    @(negedge clock);
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, 7'(r + 8), 8'(r), 8'(r * 3));
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 200 && n < 5; k++) begin
      if ($countones(req_ready) > 1) multi++;
      if (rsp_valid != 0) begin
        order[n] = grant_id;
        n++;
      end
      if (n < 5) begin
        @(negedge clock); #1;
      end
    end
    @(negedge clock);
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (order[k] !== want[k]) begin
        errors++;
        $display("FAIL rr_order_%0d got %0d want %0d", k, order[k], want[k]);
      end
    end
    checks++;
    if (multi !== 0) begin
      errors++; $display("FAIL rr_multi_hot got %0d cycles want 0", multi);
    end
  endtask

  task automatic test_external_busy;
    int bad; logic [3:0] rv;
    bad = 0; rv = '0;
    model_on = 1; model_delay = 1; model_len = 2;
    @(negedge clock);
    force_busy = 1'b1;
    set_req(1, 1'b0, 7'h11, 8'h22, 8'h33);
    req_valid[1] = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (req_ready !== 4'b0) bad++;
      @(negedge clock); #1;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL ext_busy_ready got %0d ready cycles want 0", bad);
    end
    @(negedge clock);
    force_busy = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL ext_busy_release got %b want 0010", req_ready);
    end
    @(negedge clock);
    req_valid[1] = 1'b0;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (rsp_valid != 0) begin
        rv = rsp_valid;
        break;
      end
      @(negedge clock); #1;
    end
    checks++;
    if (rv !== 4'b0010) begin
      errors++; $display("FAIL ext_busy_rsp got %b want 0010", rv);
    end
  endtask

  task automatic test_reset_mid;
    int acc; logic [1:0] g [2]; int n;
    acc = 0; n = 0; g[0] = 2'bxx; g[1] = 2'bxx;
    model_on = 1; model_delay = 1; model_len = 30;
    @(negedge clock);
    set_req(0, 1'b1, 7'h3C, 8'h44, 8'h55);
    divider_cfg = 16'h1234;
    req_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready[0]) begin
        acc = 1;
        break;
      end
      @(negedge clock); #1;
    end
    @(negedge clock);
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    checks++;
    if (acc !== 1 || busy !== 1'b1 || device_address !== 7'h3C) begin
      errors++;
      $display("FAIL mid_setup got acc %0d busy %b dev %h want 1 1 3c",
               acc, busy, device_address);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({enable, rsp_valid, req_ready} !== 9'h0) begin
      errors++;
      $display("FAIL mid_reset_ctrl got %b want 0", {enable, rsp_valid, req_ready});
    end
    checks++;
    if ({grant_id, rsp_error, rsp_miso_data, read_write, device_address,
         register_address, mosi_data, divider} !== 51'h0) begin
      errors++;
      $display("FAIL mid_reset_data got dev %h div %h want 0",
               device_address, divider);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_len = 2;
    set_req(1, 1'b0, 7'h01, 8'h02, 8'h03);
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_first_ready got %b want 0001", req_ready);
    end
    for (int k = 0; k < 100 && n < 2; k++) begin
      if (rsp_valid != 0) begin
        g[n] = grant_id;
        n++;
      end
      if (n < 2) begin
        @(negedge clock); #1;
      end
    end
    @(negedge clock);
    req_valid = '0;
    checks++;
    if (g[0] !== 2'd0 || g[1] !== 2'd1) begin
      errors++; $display("FAIL mid_order got %0d,%0d want 0,1", g[0], g[1]);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    reset_n = 1'b0;
    req_valid = '0;
    req_read_write = '0;
    req_device_address = '0;
    req_register_address = '0;
    req_mosi_data = '0;
    divider_cfg = '0;
    force_busy = 1'b0;
    model_on = 0; model_delay = 1; model_len = 1; model_miso = '0;
    test_reset();
    test_single_write();
    test_read();
    test_timeout();
    test_round_robin();
    test_external_busy();
    test_reset_mid();
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
